store_queue_unit: RTL and testbench

Parametrised, buffered successor to the core's combinational store path. Accepts store requests from the execute stage, checks alignment, formats data and byte-lane masks for an XLEN-wide data bus, and queues them in a DEPTH-entry FIFO. Entries drain to data memory over a valid/ack handshake. A fence handshake and a load-hazard address check are provided to the pipeline.

---
 rtl/store_queue_unit.sv | 199 +++++++++++++++++++
 tb/tb_store_queue_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_unit.sv
// store_queue_unit: buffered store path between execute and data memory.
//
// Store requests are checked for natural alignment, lane-positioned for an XLEN-wide bus and
// queued in a DEPTH-entry FIFO that drains over a req/ack handshake. A fence handshake blocks new
// stores until the queue is empty, and a hazard check flags loads hitting a queued word.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   st_req_in, funct3_in,
//   iadder_in, rs2_in       store request, size code, byte address, right-justified data
//   st_ready_out            queue can accept a store this cycle
//   misaligned_out          one-cycle pulse after a rejected store
//   err_addr_out            address of the most recent rejected store
//   dm_req_out, dm_ack_in   head entry valid / accepted by memory
//   dm_addr_out, dm_data_out,
//   dm_wr_mask_out          head entry word address, lane data, byte enables (0 when empty)
//   chk_addr_in, chk_hit_out load hazard check against occupied entries
//   fence_req_in, fence_done_out  drain request / completion pulse
//   count_out               occupied entries
module store_queue_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         st_req_in,
    input  logic [2:0]                   funct3_in,
    input  logic [ADDR_W-1:0]            iadder_in,
    input  logic [XLEN-1:0]              rs2_in,
    output logic                         st_ready_out,
    output logic                         misaligned_out,
    output logic [ADDR_W-1:0]            err_addr_out,
    output logic                         dm_req_out,
    input  logic                         dm_ack_in,
    output logic [ADDR_W-1:0]            dm_addr_out,
    output logic [XLEN-1:0]              dm_data_out,
    output logic [XLEN/8-1:0]            dm_wr_mask_out,
    input  logic [ADDR_W-1:0]            chk_addr_in,
    output logic                         chk_hit_out,
    input  logic                         fence_req_in,
    output logic                         fence_done_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    localparam int unsigned B    = XLEN / 8;
    localparam int unsigned OFFW = $clog2(B);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    typedef enum logic {StRun, StFence} state_e;

    state_e              state_q, state_d;
    logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                misaligned_q, misaligned_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic                fence_done_q, fence_done_d;
    logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
    logic [ADDR_W-1:0]   mem_addr_d [DEPTH];
    logic [XLEN-1:0]     mem_data_q [DEPTH];
    logic [XLEN-1:0]     mem_data_d [DEPTH];
    logic [B-1:0]        mem_mask_q [DEPTH];
    logic [B-1:0]        mem_mask_d [DEPTH];

    logic [OFFW-1:0]     off;
    logic [3:0]          sz;
    logic                legal;
    logic                enq;
    logic                deq;
    logic                reject;
    logic [B-1:0]        sz_lanes;
    logic [B-1:0]        new_mask;
    logic [XLEN-1:0]     keep;
    logic [XLEN-1:0]     new_data;
    logic [ADDR_W-1:0]   new_addr;
    logic [PTRW-1:0]     rel;

    // Only the word address takes part in the hazard compare.
    logic unused_chk_low;
    assign unused_chk_low = ^chk_addr_in[OFFW-1:0];

    // Alignment check and lane formatting of the incoming store.
    always_comb begin
        off      = iadder_in[OFFW-1:0];
        sz       = 4'd1 << funct3_in[1:0];
        // For sizes that fit the bus, sz-1 fits in OFFW bits, so the truncation is harmless.
        legal    = !funct3_in[2] && (sz <= 4'(B)) && ((off & OFFW'(sz - 4'd1)) == '0);
        sz_lanes = '0;
        keep     = '0;
        for (int i = 0; i < int'(B); i++) begin
            sz_lanes[i]     = (i < int'(sz));
            keep[8*i +: 8]  = {8{sz_lanes[i]}};
        end
        new_mask = sz_lanes << off;
        new_data = (rs2_in & keep) << {off, 3'b000};
        new_addr = {iadder_in[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    end

    assign st_ready_out = (count_q < CNTW'(DEPTH)) && (state_q == StRun);
    assign enq          = st_req_in && st_ready_out && legal;
    assign reject       = st_req_in && st_ready_out && !legal;
    assign dm_req_out   = (count_q != '0);
    assign deq          = dm_req_out && dm_ack_in;

    // Queue and status next state.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTRW'(enq);
        rd_ptr_d     = rd_ptr_q + PTRW'(deq);
        count_d      = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_mask_d = mem_mask_q;
        if (enq) begin
            mem_addr_d[wr_ptr_q] = new_addr;
            mem_data_d[wr_ptr_q] = new_data;
            mem_mask_d[wr_ptr_q] = new_mask;
        end
        misaligned_d = reject;
        err_addr_d   = reject ? iadder_in : err_addr_q;
    end

    // Fence FSM: leave FENCE once the queue is observed empty; the done pulse is registered.
    always_comb begin
        state_d      = state_q;
        fence_done_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (fence_req_in) begin
                    state_d = StFence;
                end
            end
            StFence: begin
                if (count_q == '0) begin
                    state_d      = StRun;
                    fence_done_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            misaligned_q <= 1'b0;
            err_addr_q   <= '0;
            fence_done_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
                mem_mask_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
            err_addr_q   <= err_addr_d;
            fence_done_q <= fence_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_mask_q   <= mem_mask_d;
        end
    end

    // Head presentation and hazard check; stale storage is never visible.
    always_comb begin
        dm_addr_out    = dm_req_out ? mem_addr_q[rd_ptr_q] : '0;
        dm_data_out    = dm_req_out ? mem_data_q[rd_ptr_q] : '0;
        dm_wr_mask_out = dm_req_out ? mem_mask_q[rd_ptr_q] : '0;
        chk_hit_out    = 1'b0;
        rel            = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            // Entry i is occupied when its distance from the head is below the count.
            rel = PTRW'(i) - rd_ptr_q;
            if (({1'b0, rel} < count_q) &&
                (mem_addr_q[i][ADDR_W-1:OFFW] == chk_addr_in[ADDR_W-1:OFFW])) begin
                chk_hit_out = 1'b1;
            end
        end
    end

    assign misaligned_out = misaligned_q;
    assign err_addr_out   = err_addr_q;
    assign fence_done_out = fence_done_q;
    assign count_out      = count_q;

endmodule

// File: tb/tb_store_queue_unit.sv
module tb_store_queue_unit;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;

    // 32-bit instance
    logic        st_req_in, dm_ack_in, fence_req_in;
    logic [2:0]  funct3_in;
    logic [31:0] iadder_in, rs2_in, chk_addr_in;
    logic        st_ready_out, misaligned_out, dm_req_out, chk_hit_out, fence_done_out;
    logic [31:0] err_addr_out, dm_addr_out, dm_data_out;
    logic [3:0]  dm_wr_mask_out;
    logic [2:0]  count_out;

    // 64-bit instance
    logic        s64_req, s64_ack;
    logic [2:0]  s64_f3;
    logic [31:0] s64_addr;
    logic [63:0] s64_rs2;
    logic        s64_ready, s64_mis, s64_dm_req, s64_hit, s64_done;
    logic [31:0] s64_err, s64_dm_addr;
    logic [63:0] s64_dm_data;
    logic [7:0]  s64_mask;
    logic [2:0]  s64_count;

    store_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(32)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .st_req_in(st_req_in), .funct3_in(funct3_in), .iadder_in(iadder_in), .rs2_in(rs2_in),
        .st_ready_out(st_ready_out), .misaligned_out(misaligned_out),
        .err_addr_out(err_addr_out),
        .dm_req_out(dm_req_out), .dm_ack_in(dm_ack_in), .dm_addr_out(dm_addr_out),
        .dm_data_out(dm_data_out), .dm_wr_mask_out(dm_wr_mask_out),
        .chk_addr_in(chk_addr_in), .chk_hit_out(chk_hit_out),
        .fence_req_in(fence_req_in), .fence_done_out(fence_done_out), .count_out(count_out)
    );

    store_queue_unit #(.XLEN(64), .DEPTH(DEPTH), .ADDR_W(32)) u_dut64 (
        .clk_in(clk_in), .rst_in(rst_in),
        .st_req_in(s64_req), .funct3_in(s64_f3), .iadder_in(s64_addr), .rs2_in(s64_rs2),
        .st_ready_out(s64_ready), .misaligned_out(s64_mis), .err_addr_out(s64_err),
        .dm_req_out(s64_dm_req), .dm_ack_in(s64_ack), .dm_addr_out(s64_dm_addr),
        .dm_data_out(s64_dm_data), .dm_wr_mask_out(s64_mask),
        .chk_addr_in(32'h0), .chk_hit_out(s64_hit),
        .fence_req_in(1'b0), .fence_done_out(s64_done), .count_out(s64_count)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    // Reference model state (expected post-edge view of the 32-bit queue).
    entry_t      exp_q[$];
    bit          m_fence = 0;
    bit          m_mis   = 0;
    bit          m_done  = 0;
    logic [31:0] m_err   = '0;

    // Byte-by-byte reference formatting of one store for a 4-byte bus.
    function automatic void model_store(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d, output bit legal,
                                        output entry_t e);
        int off;
        int sz;
        off     = int'(a % 4);
        sz      = 1 << int'(f3 & 3'd3);
        legal   = (f3 < 3'd4) && (sz <= 4) && (off % sz == 0);
        e.addr  = a - 32'(off);
        e.data  = '0;
        e.mask  = '0;
        if (legal) begin
            for (int k = 0; k < sz; k++) begin
                e.data[8*(off+k) +: 8] = d[8*k +: 8];
                e.mask[off+k]          = 1'b1;
            end
        end
    endfunction

    bit     n_ready, n_legal, n_pop, hit;
    entry_t n_e;

    // Scoreboard monitor + model advance, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (rst_in) begin
            exp_q.delete();
            m_fence = 0;
            m_mis   = 0;
            m_done  = 0;
            m_err   = '0;
        end else begin
            n_ready = (exp_q.size() < DEPTH) && !m_fence;
            check("st_ready", st_ready_out, n_ready);
            check("count", count_out, exp_q.size());
            check("dm_req", dm_req_out, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("head_addr", dm_addr_out, exp_q[0].addr);
                check("head_data", dm_data_out, exp_q[0].data);
                check("head_mask", dm_wr_mask_out, exp_q[0].mask);
            end else begin
                check("idle_bus", {dm_addr_out, dm_data_out[27:0], dm_wr_mask_out}, 64'h0);
            end
            check("misaligned", misaligned_out, m_mis);
            check("err_addr", err_addr_out, m_err);
            check("fence_done", fence_done_out, m_done);
            hit = 0;
            foreach (exp_q[i]) if ((exp_q[i].addr >> 2) == (chk_addr_in >> 2)) hit = 1;
            check("chk_hit", chk_hit_out, hit);

            // Advance model across the coming edge.
            n_pop = (exp_q.size() != 0) && dm_ack_in;
            if (!m_fence) begin
                m_done = 0;
                if (fence_req_in) m_fence = 1;
            end else if (exp_q.size() == 0) begin
                m_fence = 0;
                m_done  = 1;
            end else begin
                m_done = 0;
            end
            model_store(funct3_in, iadder_in, rs2_in, n_legal, n_e);
            m_mis = st_req_in && n_ready && !n_legal;
            if (m_mis) m_err = iadder_in;
            if (n_pop) void'(exp_q.pop_front());
            if (st_req_in && n_ready && n_legal) exp_q.push_back(n_e);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_req_in = 1'b1;
        funct3_in = f3;
        iadder_in = a;
        rs2_in    = d;
    endtask

    int done_cnt;

    initial begin
        rst_in = 1'b1;
        st_req_in = 0; dm_ack_in = 0; fence_req_in = 0;
        funct3_in = 0; iadder_in = 0; rs2_in = 0; chk_addr_in = 0;
        s64_req = 0; s64_ack = 0; s64_f3 = 0; s64_addr = 0; s64_rs2 = 0;
        step();
        step();
        check("rst_count", count_out, 0);
        check("rst_ready", st_ready_out, 1);
        check("rst_dm_req", dm_req_out, 0);
        check("rst_bus", {dm_addr_out, dm_data_out}, 64'h0);
        check("rst_mask", dm_wr_mask_out, 0);
        check("rst_flags", {misaligned_out, fence_done_out, chk_hit_out}, 0);
        check("rst_err", err_addr_out, 0);
        rst_in = 1'b0;
        step();

        // SB at 0x1003
        store(3'b000, 32'h1003, 32'hAABBCCDD);
        step();
        st_req_in = 0;
        check("sb_req", dm_req_out, 1);
        check("sb_addr", dm_addr_out, 32'h1000);
        check("sb_data", dm_data_out, 32'hDD000000);
        check("sb_mask", dm_wr_mask_out, 4'b1000);
        dm_ack_in = 1;
        step();
        dm_ack_in = 0;
        check("sb_drained", count_out, 0);

        // SH at 0x2002, then illegal SW at 0x2002
        store(3'b001, 32'h2002, 32'h1234ABCD);
        step();
        check("sh_data", dm_data_out, 32'hABCD0000);
        check("sh_mask", dm_wr_mask_out, 4'b1100);
        store(3'b010, 32'h2002, 32'h0);
        step();
        st_req_in = 0;
        check("sw_mis", misaligned_out, 1);
        check("sw_err", err_addr_out, 32'h2002);
        check("sw_not_enq", count_out, 1);
        step();
        check("mis_pulse_end", misaligned_out, 0);
        check("err_held", err_addr_out, 32'h2002);
        dm_ack_in = 1;
        step();
        dm_ack_in = 0;

        // SD on a 32-bit bus is illegal
        store(3'b011, 32'h8, 32'h1);
        step();
        st_req_in = 0;
        check("sd32_mis", misaligned_out, 1);
        check("sd32_count", count_out, 0);

        // Fill to full, hold off the fifth store, then wrap pointers over 10 stores
        for (int i = 0; i < 4; i++) begin
            store(3'b010, 32'h100 + 32'(4 * i), 32'(i + 1));
            step();
        end
        check("full_count", count_out, 4);
        check("full_ready", st_ready_out, 0);
        store(3'b010, 32'h110, 32'd5);
        step();
        check("full_hold", count_out, 4);
        dm_ack_in = 1;
        step();
        check("full_ack_no_enq", count_out, 3);
        for (int i = 4; i < 10; i++) begin
            store(3'b010, 32'h100 + 32'(4 * i), 32'(i + 1));
            step();
            check("wrap_count", count_out, 3);
        end
        st_req_in = 0;
        repeat (3) step();
        dm_ack_in = 0;
        check("wrap_drained", count_out, 0);

        // Hazard check
        store(3'b010, 32'h3004, 32'h55);
        step();
        st_req_in = 0;
        chk_addr_in = 32'h3007;
        #1 check("hit_same_word", chk_hit_out, 1);
        chk_addr_in = 32'h3008;
        #1 check("hit_next_word", chk_hit_out, 0);
        dm_ack_in = 1;
        step();
        dm_ack_in = 0;
        chk_addr_in = 32'h3007;
        #1 check("hit_after_drain", chk_hit_out, 0);

        // Fence with three queued entries
        for (int i = 0; i < 3; i++) begin
            store(3'b010, 32'h500 + 32'(4 * i), 32'(i));
            step();
        end
        st_req_in = 0;
        fence_req_in = 1;
        step();
        fence_req_in = 0;
        dm_ack_in = 1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) store(3'b010, 32'h5001, 32'h0);
            else st_req_in = 0;
            step();
            if (i < 3) begin
                check("fence_ready_low", st_ready_out, 0);
                check("fence_no_mis", misaligned_out, 0);
            end
            if (fence_done_out) done_cnt++;
        end
        dm_ack_in = 0;
        check("fence_done_once", done_cnt, 1);

        // Fence on an empty queue
        fence_req_in = 1;
        step();
        fence_req_in = 0;
        check("efence_ready", st_ready_out, 0);
        check("efence_wait", fence_done_out, 0);
        step();
        check("efence_done", fence_done_out, 1);
        check("efence_run", st_ready_out, 1);
        step();
        check("efence_pulse_end", fence_done_out, 0);

        // Reset in the middle of a fence
        store(3'b010, 32'h600, 32'h1);
        step();
        store(3'b010, 32'h604, 32'h2);
        step();
        st_req_in = 0;
        fence_req_in = 1;
        step();
        fence_req_in = 0;
        step();
        #2 rst_in = 1'b1;
        #1;
        check("arst_count", count_out, 0);
        check("arst_req", dm_req_out, 0);
        check("arst_ready", st_ready_out, 1);
        step();
        step();
        rst_in = 1'b0;
        done_cnt = 0;
        repeat (4) begin
            step();
            if (fence_done_out) done_cnt++;
        end
        check("arst_no_done", done_cnt, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            st_req_in    = ($urandom_range(0, 9) < 7);
            funct3_in    = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 2))
                                                      : 3'($urandom_range(0, 7));
            iadder_in    = 32'h4000 + 32'($urandom_range(0, 31));
            rs2_in       = $urandom;
            chk_addr_in  = 32'h4000 + 32'($urandom_range(0, 31));
            dm_ack_in    = $urandom_range(0, 1) == 1;
            fence_req_in = ($urandom_range(0, 99) < 3);
            step();
        end
        st_req_in = 0;
        fence_req_in = 0;
        dm_ack_in = 1;
        repeat (10) step();
        dm_ack_in = 0;
        check("rand_drained", count_out, 0);

        // 64-bit bus
        s64_req = 1; s64_f3 = 3'b011; s64_addr = 32'h8; s64_rs2 = 64'h1122334455667788;
        step();
        s64_req = 0;
        check("sd64_req", s64_dm_req, 1);
        check("sd64_addr", s64_dm_addr, 32'h8);
        check("sd64_data", s64_dm_data, 64'h1122334455667788);
        check("sd64_mask", s64_mask, 8'hFF);
        s64_ack = 1;
        step();
        s64_ack = 0;
        check("sd64_drained", s64_count, 0);
        s64_req = 1; s64_f3 = 3'b010; s64_addr = 32'hC; s64_rs2 = 64'hDEADBEEFCAFEF00D;
        step();
        s64_req = 0;
        check("sw64_addr", s64_dm_addr, 32'h8);
        check("sw64_data", s64_dm_data, 64'hCAFEF00D00000000);
        check("sw64_mask", s64_mask, 8'hF0);
        s64_ack = 1;
        step();
        s64_ack = 0;
        s64_req = 1; s64_f3 = 3'b011; s64_addr = 32'h4;
        step();
        s64_req = 0;
        check("sd64_mis", s64_mis, 1);
        check("sd64_err", s64_err, 32'h4);
        check("sd64_mis_count", s64_count, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
